// File: rtl/keccak_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : keccak_pkg
//  Description : Shared constants and types for the Keccak sponge absorb side.
//                Holds lane/rate geometry for SHAKE128, the padding bytes and
//                the absorb-buffer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package keccak_pkg;

   localparam int DATA_SIZE     = 64;
   localparam int RATE_SHAKE128 = 1344;
   localparam int LANES         = 21;
   localparam int LANE_CNT_W    = 5;

   localparam logic [LANE_CNT_W-1:0] LAST_LANE = LANE_CNT_W'(LANES - 1);

   localparam logic [7:0] DOMAIN_SHAKE = 8'h1F;
   localparam logic [7:0] PAD_END      = 8'h80;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      PAD  = 2'd1,
      FULL = 2'd2
   } state_t;

endpackage : keccak_pkg
`default_nettype wire

// File: rtl/sipo_absorb_reg_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sipo_absorb_reg_if
//  Description : Lane-input and block-output handshake bundle of the absorb
//                buffer.
//                  data_in/in_valid/in_last -> lane stream into the buffer
//                  in_ready                 <- buffer accepts a lane
//                  block_out/block_valid/block_last -> assembled rate block
//                  block_ready              -> downstream consumes the block
//                  lane_cnt                 <- index of the next lane slot
//                slave  : the absorb buffer side
//                master : the producer/consumer side
//  Revision    : 1.0 - initial release
// ============================================================================
interface sipo_absorb_reg_if;
   import keccak_pkg::*;

   logic [DATA_SIZE-1:0]     data_in;
   logic                     in_valid;
   logic                     in_last;
   logic                     in_ready;
   logic [RATE_SHAKE128-1:0] block_out;
   logic                     block_valid;
   logic                     block_last;
   logic                     block_ready;
   logic [LANE_CNT_W-1:0]    lane_cnt;

   modport slave (
      input  data_in, in_valid, in_last, block_ready,
      output in_ready, block_out, block_valid, block_last, lane_cnt
   );

   modport master (
      output data_in, in_valid, in_last, block_ready,
      input  in_ready, block_out, block_valid, block_last, lane_cnt
   );

endinterface : sipo_absorb_reg_if
`default_nettype wire

// File: rtl/keccak_pad_lane.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : keccak_pad_lane
//  Description : Combinational builder of one pad10*1 padding lane.
//                  first_pad (in)  - this is the first pad lane of the message
//                  last_lane (in)  - the lane lands in the final block slot
//                  lane      (out) - padding lane value
//                Both bytes may be present in the same lane when the message
//                ends one lane short of a full block.
//  Revision    : 1.0 - initial release
// ============================================================================
module keccak_pad_lane
   import keccak_pkg::*;
#(
   parameter logic [7:0] DOMAIN_BYTE = DOMAIN_SHAKE
)(
   input  logic                 first_pad,
   input  logic                 last_lane,
   output logic [DATA_SIZE-1:0] lane
);

   always_comb begin
      lane = '0;
      if (first_pad) begin
         lane[7:0] = lane[7:0] | DOMAIN_BYTE;
      end
      if (last_lane) begin
         lane[DATA_SIZE-1 -: 8] = lane[DATA_SIZE-1 -: 8] | PAD_END;
      end
   end

endmodule : keccak_pad_lane
`default_nettype wire

// File: rtl/sipo_absorb_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sipo_absorb_reg
//  Description : Serial-in/parallel-out absorb buffer for the SHAKE128 sponge.
//                Collects 64-bit lanes into 1344-bit rate blocks, appends
//                pad10*1 padding with domain byte 0x1F at lane granularity,
//                and presents each block over a valid/ready handshake. The
//                first lane received ends up in the top slot of the block.
//                  clk   (in) - clock, rising edge
//                  rst_n (in) - asynchronous active-low reset
//                  bus   (slave) - lane input / block output handshakes
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo_absorb_reg
   import keccak_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   sipo_absorb_reg_if.slave bus
);

   state_t                   r_state;
   logic [RATE_SHAKE128-1:0] r_data;
   logic [LANE_CNT_W-1:0]    r_lane_cnt;
   logic                     r_block_last;
   logic                     r_pad_pending;
   logic                     r_first_pad;

   logic                     w_last_slot;
   logic                     w_in_xfer;
   logic                     w_blk_xfer;
   logic [DATA_SIZE-1:0]     w_pad_lane;

   assign w_last_slot = (r_lane_cnt == LAST_LANE);
   assign w_in_xfer   = bus.in_valid    && (r_state == FILL);
   assign w_blk_xfer  = bus.block_ready && (r_state == FULL);

   keccak_pad_lane #(
      .DOMAIN_BYTE (DOMAIN_SHAKE)
   ) u_pad_lane (
      .first_pad (r_first_pad),
      .last_lane (w_last_slot),
      .lane      (w_pad_lane)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= FILL;
         r_data        <= '0;
         r_lane_cnt    <= '0;
         r_block_last  <= 1'b0;
         r_pad_pending <= 1'b0;
         r_first_pad   <= 1'b0;
      end else begin
         case (r_state)
            FILL: begin
               if (w_in_xfer) begin
                  r_data <= {r_data[RATE_SHAKE128-DATA_SIZE-1:0], bus.data_in};
                  if (w_last_slot) begin
                     // Block is full of message data; if the message also
                     // ends here, padding needs a whole extra block.
                     r_lane_cnt   <= '0;
                     r_state      <= FULL;
                     r_block_last <= 1'b0;
                     if (bus.in_last) begin
                        r_pad_pending <= 1'b1;
                     end
                  end else begin
                     r_lane_cnt <= r_lane_cnt + LANE_CNT_W'(1);
                     if (bus.in_last) begin
                        r_first_pad <= 1'b1;
                        r_state     <= PAD;
                     end
                  end
               end
            end

            PAD: begin
               r_data <= {r_data[RATE_SHAKE128-DATA_SIZE-1:0], w_pad_lane};
               // Domain byte goes only into the first pad lane.
               r_first_pad <= 1'b0;
               if (w_last_slot) begin
                  r_lane_cnt   <= '0;
                  r_state      <= FULL;
                  r_block_last <= 1'b1;
               end else begin
                  r_lane_cnt <= r_lane_cnt + LANE_CNT_W'(1);
               end
            end

            FULL: begin
               if (w_blk_xfer) begin
                  if (r_pad_pending) begin
                     r_pad_pending <= 1'b0;
                     r_first_pad   <= 1'b1;
                     r_lane_cnt    <= '0;
                     r_data        <= '0;
                     r_state       <= PAD;
                  end else begin
                     r_state <= FILL;
                  end
               end
            end

            default: begin
               r_state <= FILL;
            end
         endcase
      end
   end

   // Handshake flags depend on state only, so no combinational path runs
   // from block_ready to in_ready.
   assign bus.in_ready    = (r_state == FILL);
   assign bus.block_valid = (r_state == FULL);
   assign bus.block_out   = r_data;
   assign bus.block_last  = r_block_last;
   assign bus.lane_cnt    = r_lane_cnt;

endmodule : sipo_absorb_reg
`default_nettype wire

// File: doc/sipo_absorb_reg.md
# sipo_absorb_reg

Serial-in/parallel-out absorb buffer for the Keccak sponge input side. It accepts a message as a stream of 64-bit lanes over a valid/ready handshake and assembles them into 1344-bit rate blocks. It applies SHAKE128 multi-rate padding (domain byte 0x1F, pad10*1) at word granularity and hands each block to the permutation core over a valid/ready handshake. Lane ordering mirrors the output PISO: the first lane received sits at the top of the block.

## Interface
- DATA_SIZE, 64: lane width in bits.
- RATE, 1344: block width in bits; must equal LANES*DATA_SIZE.
- LANES, 21: lanes per block (RATE/DATA_SIZE).
- DOMAIN_BYTE, 8'h1F: domain-separation and first-pad byte.

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- data_in  in  DATA_SIZE  message lane.
- in_valid  in  1  data_in is valid.
- in_last  in  1  qualifies the final lane of the message; meaningful only when in_valid=1.
- in_ready  out  1  buffer accepts a lane this cycle.
- block_out  out  RATE  assembled block; lane w occupies bits [RATE-1-DATA_SIZE*w -: DATA_SIZE].
- block_valid  out  1  block_out is complete and stable.
- block_last  out  1  the block is the final (padded) block of the message; qualified by block_valid.
- block_ready  in  1  downstream consumes the block.
- lane_cnt  out  5  index of the next lane slot, 0..LANES-1.

## Operation
- States: FILL, PAD, FULL. The reset state is FILL.
- A lane transfer occurs when in_valid and in_ready are both 1. A block transfer occurs when block_valid and block_ready are both 1.
- in_ready = (state==FILL). block_valid = (state==FULL). Both are combinational from state only.
- Shift rule: on every accepted or padded lane, data <= {data[RATE-DATA_SIZE-1:0], lane}. After LANES lanes, the first lane sits in the top slot.
- FILL, transfer with lane_cnt<LANES-1 and in_last=0: shift in, lane_cnt+1.
- FILL, transfer with lane_cnt=LANES-1 and in_last=0: shift in, lane_cnt<=0, go to FULL, block_last<=0.
- FILL, transfer with lane_cnt<LANES-1 and in_last=1: shift in, lane_cnt+1, set first_pad, go to PAD.
- FILL, transfer with lane_cnt=LANES-1 and in_last=1: shift in, go to FULL, block_last<=0, set pad_pending. An all-pad block must follow.
- PAD: inserts one lane per cycle with no input handshake. The lane value is built as follows:
  - start from 0;
  - OR in DOMAIN_BYTE at bits [7:0] if this is the first pad lane;
  - OR in 8'h80 at bits [63:56] if lane_cnt=LANES-1.
- PAD continues until the lane at index LANES-1 is inserted. It then goes to FULL with block_last<=1, lane_cnt<=0, and clears first_pad.
- FULL, on block transfer:
  - if pad_pending: clear it, set first_pad, go to PAD at lane_cnt=0, clear data;
  - otherwise go to FILL.
- FULL holds block_out, block_last and lane_cnt stable while block_ready=0.
- Reset (rst_n low, any state, mid-block or mid-pad) clears data, lane_cnt, block_last, pad_pending and first_pad, and forces FILL.
- Reset values: block_out=0, block_valid=0, block_last=0, lane_cnt=0, in_ready=1. in_ready is 1 because it is derived from the FILL reset state.
- An empty message is not supported. Every message has at least one lane with in_last=1.

## Timing
- A lane accepted at edge N appears in block_out at edge N.
- The 21st lane accepted at edge N gives block_valid=1 in the cycle after edge N.
- in_last on lane index k<20 at edge N: pad lanes k+1..20 occupy the following 20-k cycles, and block_valid rises after edge N+20-k.
- in_last on index 20: the data block is valid after edge N. After its transfer at edge M, the all-pad block takes 21 cycles and is valid after edge M+21.
- There is no bypass: in_ready=0 throughout PAD and FULL, including the cycle of the block transfer. Sustained throughput is 21 lanes per 22 cycles.
- in_valid and in_last are ignored while in_ready=0.

## Structure
- A shared package keccak_pkg holds:
  - DATA_SIZE=64, RATE_SHAKE128=1344, LANES=21;
  - DOMAIN_SHAKE=8'h1F, PAD_END=8'h80;
  - the state enum {FILL, PAD, FULL}.
- One sub-module is natural: keccak_pad_lane. It is combinational and builds the pad lane from first_pad and (lane_cnt==LANES-1).
- The FSM, counter and shift register stay in the top module.

## Test plan
- 21 lanes 64'h0..64'h14, in_last on the 21st, block_ready=1:
  - block 1 is valid 1 cycle later, top lane 64'h0, bottom lane 64'h14, block_last=0;
  - block 2 is all-pad: top lane 64'h1F, lanes 1..19 zero, bottom lane 64'h8000000000000000, block_last=1.
- Single lane 64'hDEADBEEF with in_last: block_valid rises after 20 pad cycles. Top lane 64'hDEADBEEF, lane 1 64'h1F, lanes 2..19 zero, lane 20 64'h8000000000000000, block_last=1.
- 20 lanes with in_last on the 20th: one pad cycle, and lane 20 = 64'h800000000000001F.
- Hold block_ready=0 for 10 cycles in FULL while in_valid=1: block_out and lane_cnt stay stable, in_ready=0 and no lanes are taken. Raise block_ready: the block transfers and in_ready=1 on the next cycle.
- Random in_valid gaps (30% idle) over a 3-block message: blocks match the reference-model padded stream, and no lane is dropped or duplicated.
- Assert rst_n=0 mid-PAD with lane_cnt=7: all outputs are at reset values immediately. After release, a fresh 21-lane block assembles correctly.
